// File: rtl/alu_seq.sv
// alu_seq: N-bit sequenced ALU.
//   Single-cycle ops (ADD/SUB/ADC/SBC/AND/OR/XOR/SHL/SHR/pass) latch their
//   result and pending flags on the start edge. MUL is an N-step shift-add
//   multiply. The pending flags reach the visible flags only on a fi_ strobe.
//
// Ports:
//   clk, rst_        rising-edge clock, asynchronous active-low reset
//   a, b, op, start  operands and opcode, captured on a start edge in IDLE
//   eo_              active-low enable that drives result onto bus
//   fi_              active-low strobe: pending flags -> visible flags
//   bus              result when eo_=0, otherwise high-Z
//   cf, zf, nf, vf   visible carry / zero / negative / overflow flags
//   busy, done       busy while not IDLE; done pulses for one cycle
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    input  logic         start,
    input  logic         eo_,
    input  logic         fi_,
    inout  wire  [N-1:0] bus,
    output logic         cf,
    output logic         zf,
    output logic         nf,
    output logic         vf,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    state_t         state_q, state_d;
    logic [N-1:0]   result;
    flags_t         pend;

    // multiplier datapath
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_nx;
    logic [CW-1:0]  cnt;
    logic           mul_last;

    // single-cycle datapath
    logic [N-1:0]   bx;
    logic           cin;
    logic [N:0]     sum;
    logic           add_v;
    logic [N-1:0]   alu_r;
    logic           alu_c;
    logic           alu_v;

    // One shared adder covers ADD/SUB/ADC/SBC: subtraction is a + ~b + cin.
    // The carry-in for ADC/SBC is the visible cf at the start edge.
    always_comb begin
        bx  = b;
        cin = 1'b0;
        case (op)
            4'd1: begin bx = ~b; cin = 1'b1; end
            4'd2: begin bx = b;  cin = cf;   end
            4'd3: begin bx = ~b; cin = cf;   end
            default: ;
        endcase
    end

    assign sum   = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, cin};
    // signed overflow: both addends share a sign that the sum does not
    assign add_v = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);

    always_comb begin
        alu_r = a;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_r = sum[N-1:0];
                alu_c = sum[N];
                alu_v = add_v;
            end
            4'd4: alu_r = a & b;
            4'd5: alu_r = a | b;
            4'd6: alu_r = a ^ b;
            4'd7: begin
                alu_r = {a[N-2:0], 1'b0};
                alu_c = a[N-1];
            end
            4'd8: begin
                alu_r = {1'b0, a[N-1:1]};
                alu_c = a[0];
            end
            default: alu_r = a;
        endcase
    end

    assign acc_nx   = acc + (mplier[0] ? mcand : {2*N{1'b0}});
    assign mul_last = (cnt == CW'(N - 1));

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (op == 4'd9) ? MUL : DONE;
            MUL:  if (mul_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            result <= '0;
            pend   <= '0;
            cf     <= 1'b0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            vf     <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            // Non-blocking copy: a strobe on the same edge as a latch
            // publishes the previous pending flags.
            if (!fi_) begin
                cf <= pend.c;
                zf <= pend.z;
                nf <= pend.n;
                vf <= pend.v;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == 4'd9) begin
                            mcand  <= {{N{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result <= alu_r;
                            pend   <= '{c: alu_c, z: (alu_r == '0),
                                        n: alu_r[N-1], v: alu_v};
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nx;
                    mcand  <= {mcand[2*N-2:0], 1'b0};
                    mplier <= {1'b0, mplier[N-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (mul_last) begin
                        result <= acc_nx[N-1:0];
                        // cf flags a product that did not fit in N bits
                        pend   <= '{c: (acc_nx[2*N-1:N] != '0),
                                    z: (acc_nx[N-1:0] == '0),
                                    n: acc_nx[N-1], v: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bus  = eo_ ? {N{1'bz}} : result;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): a scoreboard queue holds the expected
// result/flags of every issued op and is popped when done pulses.
module tb_alu_seq;

    localparam int N = 8;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;   // {c, z, n, v}
    } exp_t;

    logic         clk;
    logic         rst_;
    logic [N-1:0] a, b;
    logic [3:0]   op;
    logic         start, eo_, fi_;
    wire  [N-1:0] bus;
    logic         cf, zf, nf, vf, busy, done;
    logic         tb_en;
    logic [N-1:0] tb_val;

    logic [3:0]   flg;
    exp_t         q[$];
    logic [3:0]   m_pend, m_vis, old_pend;
    logic [7:0]   last_res;
    int           n_asrt, n_fail;

    assign flg = {cf, zf, nf, vf};
    // external driver on the shared bus, used only while eo_=1
    assign bus = tb_en ? tb_val : 8'hzz;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst_(rst_), .a(a), .b(b), .op(op), .start(start),
        .eo_(eo_), .fi_(fi_), .bus(bus), .cf(cf), .zf(zf), .nf(nf),
        .vf(vf), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model written from integer arithmetic
    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                   input logic [7:0] y, input logic c);
        exp_t e;
        int ux, uy, sx, sy, ci, s, ss;
        logic [31:0] sv;
        logic cc, vv;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        ci = c ? 1 : 0;
        s  = ux; ss = 0; cc = 1'b0; vv = 1'b0;
        case (o)
            4'd0: begin s = ux + uy;          ss = sx + sy;          cc = (s > 255);            vv = 1'b1; end
            4'd1: begin s = ux - uy;          ss = sx - sy;          cc = (ux >= uy);           vv = 1'b1; end
            4'd2: begin s = ux + uy + ci;     ss = sx + sy + ci;     cc = (s > 255);            vv = 1'b1; end
            4'd3: begin s = ux - uy - 1 + ci; ss = sx - sy - 1 + ci; cc = (ux >= uy + 1 - ci);  vv = 1'b1; end
            4'd4: s = ux & uy;
            4'd5: s = ux | uy;
            4'd6: s = ux ^ uy;
            4'd7: begin s = ux * 2;  cc = (ux >= 128); end
            4'd8: begin s = ux / 2;  cc = (ux % 2 == 1); end
            4'd9: begin s = ux * uy; cc = (s > 255); end
            default: s = ux;
        endcase
        sv  = 32'(s);
        e.r = sv[7:0];
        if (vv) vv = (ss < -128) || (ss > 127);
        e.f = {cc, (e.r == 8'h00), e.r[7], vv};
        return e;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y, input bit fi_edge);
        exp_t e;
        e = model(o, x, y, m_vis[3]);
        q.push_back(e);
        a = x; b = y; op = o; start = 1'b1;
        if (fi_edge) fi_ = 1'b0;
        step();
        start = 1'b0;
        fi_   = 1'b1;
        if (fi_edge) m_vis = m_pend;
        m_pend   = e.f;
        last_res = e.r;
    endtask

    // lat = edges still expected before done goes high
    task automatic finish_op(input int lat, input string tag);
        int waited, bcnt;
        exp_t e;
        waited = 0;
        bcnt   = 0;
        while (done !== 1'b1 && waited < 64) begin
            if (busy === 1'b1) bcnt++;
            step();
            waited++;
        end
        if (done === 1'b1) bcnt++;
        chk({tag, "_lat"}, 16'(waited), 16'(lat));
        chk({tag, "_busy"}, 16'(bcnt), 16'(lat + 1));
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_bus"}, {8'h00, bus}, {8'h00, e.r});
        end
        step();
    endtask

    task automatic strobe(input string tag);
        fi_ = 1'b0;
        step();
        fi_   = 1'b1;
        m_vis = m_pend;
        chk({tag, "_flags"}, {12'h000, flg}, {12'h000, m_vis});
    endtask

    initial begin
        n_asrt = 0; n_fail = 0;
        rst_ = 1'b0; a = '0; b = '0; op = '0; start = 1'b0;
        eo_ = 1'b0; fi_ = 1'b1; tb_en = 1'b0; tb_val = '0;
        m_pend = '0; m_vis = '0; last_res = '0;

        #12;
        chk("rst_bus",   {8'h00, bus}, 16'h0000);
        chk("rst_flags", {12'h000, flg}, 16'h0000);
        chk("rst_busy",  {15'h0, busy}, 16'h0000);
        chk("rst_done",  {15'h0, done}, 16'h0000);
        rst_ = 1'b1;
        step();

        issue(4'd0, 8'd34, 8'd12, 1'b0);
        chk("add_done_next", {15'h0, done}, 16'h0001);
        finish_op(0, "add34_12");
        strobe("add34_12");

        issue(4'd1, 8'd34, 8'd12, 1'b0);  finish_op(0, "sub34_12");  strobe("sub34_12");
        issue(4'd1, 8'd12, 8'd34, 1'b0);  finish_op(0, "sub12_34");  strobe("sub12_34");
        issue(4'd0, 8'd200, 8'd56, 1'b0); finish_op(0, "add200_56"); strobe("add200_56");
        issue(4'd0, 8'd100, 8'd100, 1'b0); finish_op(0, "add100_100"); strobe("add100_100");

        // strobe on the latch edge publishes the previous op's flags
        old_pend = m_pend;
        issue(4'd7, 8'h81, 8'h00, 1'b1);
        chk("fi_same_edge", {12'h000, flg}, {12'h000, old_pend});
        finish_op(0, "shl81");
        strobe("shl81");

        // carry chain
        issue(4'd0, 8'd255, 8'd1, 1'b0); finish_op(0, "add255_1"); strobe("add255_1");
        issue(4'd2, 8'd0, 8'd0, 1'b0);   finish_op(0, "adc0_0");
        issue(4'd3, 8'd5, 8'd3, 1'b0);   finish_op(0, "sbc5_3");   strobe("sbc5_3");
        issue(4'd4, 8'hF0, 8'h3C, 1'b0); finish_op(0, "and");      strobe("and");
        issue(4'd8, 8'h81, 8'h00, 1'b0); finish_op(0, "shr81");    strobe("shr81");

        // multiply
        issue(4'd9, 8'd13, 8'd11, 1'b0); finish_op(N, "mul13_11"); strobe("mul13_11");
        issue(4'd9, 8'd20, 8'd20, 1'b0); finish_op(N, "mul20_20"); strobe("mul20_20");

        // asynchronous reset after four multiply steps
        issue(4'd9, 8'd13, 8'd11, 1'b0);
        repeat (4) step();
        rst_ = 1'b0;
        #1;
        q.delete();
        m_pend = '0; m_vis = '0; last_res = '0;
        chk("rstmul_busy",  {15'h0, busy}, 16'h0000);
        chk("rstmul_done",  {15'h0, done}, 16'h0000);
        chk("rstmul_bus",   {8'h00, bus}, 16'h0000);
        chk("rstmul_flags", {12'h000, flg}, {12'h000, m_vis});
        #1;
        rst_ = 1'b1;
        step();
        issue(4'd0, 8'd5, 8'd6, 1'b0); finish_op(0, "add_after_rst"); strobe("add_after_rst");

        // operands change and start re-asserts mid-multiply: both ignored
        issue(4'd9, 8'd7, 8'd9, 1'b0);
        a = 8'd255; b = 8'd255; op = 4'd0; start = 1'b1;
        step();
        step();
        start = 1'b0;
        finish_op(N - 2, "mul7_9");
        chk("idle_after_mul_busy", {15'h0, busy}, 16'h0000);
        chk("idle_after_mul_done", {15'h0, done}, 16'h0000);
        strobe("mul7_9");

        // bus release and drive
        eo_ = 1'b1; tb_val = 8'hA5; tb_en = 1'b1;
        #1;
        chk("bus_released", {8'h00, bus}, 16'h00A5);
        tb_en = 1'b0; eo_ = 1'b0;
        #1;
        chk("bus_driven", {8'h00, bus}, {8'h00, last_res});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised N-bit sequenced ALU for kwanCPU; successor to the combinational add/subtract ALU.
- Adds an opcode-selected operation set, a registered result, and a flags register with a separate load strobe.
- Adds carry-chained ADC/SBC and a multi-cycle shift-add multiply with a start/busy/done handshake.
- Drives the shared data bus through a tri-state output gated by an active-low enable.

Parameters:
N, 8, datapath width in bits (N >= 2)

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous active-low reset
a  in  N  operand A, sampled on start
b  in  N  operand B, sampled on start
op  in  4  opcode, sampled on start
start  in  1  begin operation; honoured only in IDLE
eo_  in  1  active-low bus output enable
fi_  in  1  active-low flags-load strobe
bus  inout  N  result when eo_=0, else high-Z
cf  out  1  carry flag (visible)
zf  out  1  zero flag (visible)
nf  out  1  negative flag, result MSB (visible)
vf  out  1  signed overflow flag (visible)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: result/pending flags valid

Behaviour:
- Reset (rst_=0, asynchronous, any state, including mid-MUL):
  - state=IDLE; result=0; pending flags=0; cf=zf=nf=vf=0; busy=0; done=0.
  - Any in-flight operation is aborted.
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a+~b+1
  - 2 ADC: a+b+cf
  - 3 SBC: a+~b+cf
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SHL: a<<1, cf=a[N-1]
  - 8 SHR: logical a>>1, cf=a[0]
  - 9 MUL: unsigned a*b, low N bits
  - 10-15: pass a, cf=vf=0
- Arithmetic rules:
  - cf for ops 0-3 is the N-bit adder carry-out; for SUB/SBC, cf=1 means no borrow.
  - vf for ops 0-3 = signed overflow of the effective addition; 0 for all other ops.
  - Logic ops: cf=0, vf=0.
  - zf = (result==0); nf = result[N-1] for every op.
  - ADC/SBC use the visible cf as sampled on the start edge.
- FSM states IDLE, MUL, DONE:
  - IDLE & start & op!=9: on edge k, latch result and pending flags; go to DONE.
  - IDLE & start & op=9: on edge k, capture a, b, clear accumulator and counter; go to MUL.
  - MUL: one shift-add step per edge. After N steps, result = low N bits; pending cf=1 iff high N bits !=0; go to DONE.
  - DONE: done=1 for exactly one cycle; next edge returns to IDLE.
  - start in MUL or DONE is ignored (no queueing).
- Latency (counting edges from the start edge):
  - Single-cycle ops: done high in the cycle following edge k.
  - MUL: done high after edge k+N; busy high for N+1 cycles.
  - Back-to-back operation: start may be asserted again in the cycle after DONE.
- Operands: a, b and op are captured at the start edge; changes during MUL have no effect.
- Flags:
  - Any edge with fi_=0 copies the pending flags into the visible flags.
  - If fi_=0 on the same edge that pending flags update, the visible flags take the OLD pending value.
  - fi_ is legal in any state. Visible flags otherwise hold.
- Bus:
  - bus = result combinationally when eo_=0, else all-Z; independent of state.
  - result holds its value between operations.

Test Plan:
- N=8. ADD a=34,b=12 start -> done next cycle, bus=46 with eo_=0; after fi_ pulse cf=0 zf=0 nf=0 vf=0.
- Subtract and carry edges:
  - SUB 34-12 -> 22, cf=1.
  - SUB 12-34 -> 234, cf=0, nf=1.
  - ADD 200+56 -> 0, cf=1, zf=1.
  - ADD 100+100 -> 200, vf=1, nf=1.
- Carry chain: ADD 255+1, then fi_ (cf=1); then ADC 0+0 -> 1; SBC 5-3 with cf=1 -> 2, cf=1.
- MUL timing and overflow:
  - 13*11 -> busy for 9 cycles, done after 8 edges in MUL, bus=143, cf=0.
  - 20*20 -> 144, cf=1.
  - Changing a/b mid-MUL does not alter the result.
- Reset mid-MUL at step 4: busy=0, done=0, result=0, flags=0 immediately (asynchronous); a following ADD completes normally.
- Bus and flag-strobe corners:
  - eo_=1 -> bus reads Z.
  - start during busy is ignored.
  - fi_ low on the same edge as a result latch -> visible flags show the previous op's flags.
  - SHL 0x81 -> 0x02, cf=1.
